// File: rtl/hex_scan_driver_pkg.sv
// Shared constants and the active-low hex-to-7-segment table for the scan driver.
package hex_scan_pkg;

  localparam int unsigned NUM_DIGITS = 4;
  localparam logic [7:0]  SEG_OFF    = 8'hFF;
  localparam logic [3:0]  AN_OFF     = 4'hF;

  // {g,f,e,d,c,b,a}, active-low, indexed by hex value
  localparam logic [6:0] SEG7_TABLE [16] = '{
    7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
    7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
  };

  typedef logic [1:0] digit_idx_t;

  function automatic logic [6:0] seg7(input logic [3:0] value);
    return SEG7_TABLE[value];
  endfunction

endpackage

// File: rtl/hex_scan_driver_hex7seg_lut.sv
// Combinational hex digit + decimal point to active-low {p,g..a} segment byte.
module hex7seg_lut
  import hex_scan_pkg::*;
(
  input  logic [3:0] digit,
  input  logic       point,
  output logic [7:0] segment
);

  always_comb segment = {~point, seg7(digit)};

endmodule

// File: rtl/hex_scan_driver.sv
// 4-digit common-anode 7-segment scan driver with anti-ghost blanking and frame snapshot.
// Optional leading-zero suppression is enabled by defining LEADING_ZERO_BLANK_EN.
module hex_scan_driver
  import hex_scan_pkg::*;
#(
  parameter int unsigned SCAN_DIV     = 17,
  parameter int unsigned BLANK_CYCLES = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [15:0] hex,
  input  logic [3:0]  point,
  input  logic [3:0]  LE,
  output logic [3:0]  AN,
  output logic [7:0]  SEGMENT,
  output logic        frame_start
);

  localparam int unsigned CNT_W = SCAN_DIV + 2;
  localparam logic [SCAN_DIV-1:0] BLANK_SUB = SCAN_DIV'(BLANK_CYCLES);

  logic [CNT_W-1:0]    cnt;
  logic [15:0]         shadow_hex;
  logic [3:0]          shadow_point;
  logic [3:0]          shadow_le;
  digit_idx_t          idx;
  logic [SCAN_DIV-1:0] sub;
  logic                in_blank;
  logic                zero_blank;
  logic [3:0]          digit_hex;
  logic [7:0]          lut_seg;
  logic [3:0]          an_next;
  logic [7:0]          seg_next;

  assign idx       = cnt[CNT_W-1:SCAN_DIV];
  assign sub       = cnt[SCAN_DIV-1:0];
  assign in_blank  = sub < BLANK_SUB;
  assign digit_hex = shadow_hex[{idx, 2'b00} +: 4];

  hex7seg_lut u_lut (
    .digit   (digit_hex),
    .point   (shadow_point[idx]),
    .segment (lut_seg)
  );

`ifdef LEADING_ZERO_BLANK_EN
  // A digit is suppressed when it and every more-significant digit are zero.
  always_comb begin
    zero_blank = 1'b0;
    case (idx)
      2'd3:    zero_blank = (shadow_hex[15:12] == '0);
      2'd2:    zero_blank = (shadow_hex[15:8]  == '0);
      2'd1:    zero_blank = (shadow_hex[15:4]  == '0);
      default: zero_blank = 1'b0;
    endcase
  end
`else
  assign zero_blank = 1'b0;
`endif

  always_comb begin
    an_next  = AN_OFF;
    seg_next = SEG_OFF;
    if (!in_blank) begin
      an_next = ~(4'b0001 << idx);
      if (!(shadow_le[idx] || zero_blank))
        seg_next = lut_seg;
    end
  end

  // Shadow captures on the last cycle of digit 3 so the next frame is tear-free.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt          <= '0;
      shadow_hex   <= '0;
      shadow_point <= '0;
      shadow_le    <= '1;
      AN           <= AN_OFF;
      SEGMENT      <= SEG_OFF;
      frame_start  <= 1'b0;
    end else begin
      cnt <= cnt + 1'b1;
      if (cnt == '1) begin
        shadow_hex   <= hex;
        shadow_point <= point;
        shadow_le    <= LE;
      end
      AN          <= an_next;
      SEGMENT     <= seg_next;
      frame_start <= (cnt == '0);
    end
  end

endmodule
